// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/execute memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } arb_owner_e;

  localparam int unsigned MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arb_latcnt.sv
// Access-cycle counter: o_tc flags the last of MEM_LAT cycles while i_en is held.
module mem_arb_latcnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LAT - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_tc = i_en && (r_cnt == LastCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Single-owner arbiter sharing one memory port between fetch and load/store.
// Optional ARB_STARVE_GUARD_EN forces a fetch grant after two data grants that made fetch wait.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  input  logic              i_flush,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  arb_state_e        r_state, w_state_d;
  arb_owner_e        r_owner, w_grant_owner;
  logic              r_we;
  logic              r_cancel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_grant;
  logic              w_fetch_ok;
  logic              w_tc;
`ifdef ARB_STARVE_GUARD_EN
  logic [1:0]        r_fair;
`endif

  mem_arb_latcnt #(
    .MEM_LAT(MEM_LAT)
  ) u_latcnt (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (r_state == StAccess),
    .o_tc   (w_tc)
  );

  // Grant decision; only acted on while idle.
  always_comb begin
    w_fetch_ok    = i_if_req && !i_flush;
    w_grant       = 1'b0;
    w_grant_owner = OwnFetch;
`ifdef ARB_STARVE_GUARD_EN
    if (i_d_req && !(r_fair == 2'd2 && w_fetch_ok)) begin
`else
    if (i_d_req) begin
`endif
      w_grant       = 1'b1;
      w_grant_owner = OwnData;
    end else if (w_fetch_ok) begin
      w_grant       = 1'b1;
      w_grant_owner = OwnFetch;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_grant) w_state_d = StAccess;
      StAccess: if (w_tc) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_mem_en = (r_state == StAccess);
    o_mem_we = (r_state == StAccess) && (r_owner == OwnData) && r_we;
    o_busy   = (r_state != StIdle);
    o_if_ack = (r_state == StDone) && (r_owner == OwnFetch) && !r_cancel;
    o_d_ack  = (r_state == StDone) && (r_owner == OwnData);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_owner    <= OwnFetch;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_cancel   <= 1'b0;
    end else begin
      if (r_state == StIdle && w_grant) begin
        r_owner <= w_grant_owner;
        if (w_grant_owner == OwnData) begin
          r_addr  <= i_d_addr;
          r_we    <= i_d_we;
          r_wdata <= i_d_wdata;
        end else begin
          r_addr <= i_if_addr;
          r_we   <= 1'b0;
        end
      end
      if (w_tc) begin
        if (r_owner == OwnFetch) begin
          r_if_rdata <= i_mem_rdata;
        end else if (!r_we) begin
          r_d_rdata <= i_mem_rdata;
        end
      end
      // A cancelled fetch still runs its memory cycles; only the ack is dropped.
      if (w_state_d == StIdle) begin
        r_cancel <= 1'b0;
      end else if (i_flush && r_owner == OwnFetch && r_state != StIdle) begin
        r_cancel <= 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fair <= '0;
    end else if (r_state == StIdle && w_grant) begin
      if (w_grant_owner == OwnFetch) begin
        r_fair <= '0;
      end else if (w_fetch_ok) begin
        r_fair <= r_fair + 2'd1;
      end else if (!i_if_req) begin
        r_fair <= '0;
      end
    end
  end
`endif

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: MEM_LAT=2 and MEM_LAT=1 instances share stimulus and are
// checked every cycle against a transaction-phase model, plus directed constant checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, flush = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;

  logic        if_ack2, d_ack2, mem_en2, mem_we2, busy2;
  logic [15:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2;
  logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(2), .ADDR_W(16), .DATA_W(16)) u2 (
    .i_clk(clk), .i_reset(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack2), .o_if_rdata(if_rdata2),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack2), .o_d_rdata(d_rdata2), .i_flush(flush),
    .o_mem_en(mem_en2), .o_mem_we(mem_we2), .o_mem_addr(mem_addr2),
    .o_mem_wdata(mem_wdata2), .i_mem_rdata(mem_rdata), .o_busy(busy2)
  );

  mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) u1 (
    .i_clk(clk), .i_reset(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack1), .o_if_rdata(if_rdata1),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack1), .o_d_rdata(d_rdata1), .i_flush(flush),
    .o_mem_en(mem_en1), .o_mem_we(mem_we1), .o_mem_addr(mem_addr1),
    .o_mem_wdata(mem_wdata1), .i_mem_rdata(mem_rdata), .o_busy(busy1)
  );

  // phase 0 = idle, 1..lat = memory cycles, lat+1 = ack cycle
  typedef struct packed {
    int          phase;
    logic        owner;   // 1 = data, 0 = fetch
    logic        we;
    logic        cancel;
    logic [1:0]  fair;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] ir;
    logic [15:0] dr;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t nxt(mdl_t m, int lat);
    mdl_t n = m;
    logic fetch_ok, gd;
    if (!rst_n) return '0;
    if (m.phase == 0) begin
      fetch_ok = if_req && !flush;
`ifdef ARB_STARVE_GUARD_EN
      gd = d_req && !(m.fair == 2'd2 && fetch_ok);
`else
      gd = d_req;
`endif
      if (gd) begin
        n.phase = 1; n.owner = 1'b1; n.addr = d_addr; n.we = d_we; n.wdata = d_wdata;
        n.cancel = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        if (fetch_ok) n.fair = m.fair + 2'd1;
        else if (!if_req) n.fair = 2'd0;
`endif
      end else if (fetch_ok) begin
        n.phase = 1; n.owner = 1'b0; n.addr = if_addr; n.we = 1'b0; n.cancel = 1'b0;
        n.fair = 2'd0;
      end
    end else if (m.phase <= lat) begin
      if (m.phase == lat) begin
        if (!m.owner) n.ir = mem_rdata;
        else if (!m.we) n.dr = mem_rdata;
      end
      if (flush && !m.owner) n.cancel = 1'b1;
      n.phase = m.phase + 1;
    end else begin
      n.phase = 0;
      n.cancel = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input mdl_t m, input int lat, input logic en,
                          input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic busy, input logic ia, input logic da,
                          input logic [15:0] ir, input logic [15:0] dr);
    logic xen, xwe;
    xen = (m.phase >= 1) && (m.phase <= lat);
    xwe = xen && m.owner && m.we;
    chk({nm, ".mem_en"}, 16'(en), 16'(xen));
    chk({nm, ".mem_we"}, 16'(we), 16'(xwe));
    chk({nm, ".mem_addr"}, addr, m.addr);
    if (xwe) chk({nm, ".mem_wdata"}, wdata, m.wdata);
    chk({nm, ".busy"}, 16'(busy), 16'(m.phase != 0));
    chk({nm, ".if_ack"}, 16'(ia), 16'(m.phase == lat + 1 && !m.owner && !m.cancel));
    chk({nm, ".d_ack"}, 16'(da), 16'(m.phase == lat + 1 && m.owner));
    chk({nm, ".if_rdata"}, ir, m.ir);
    chk({nm, ".d_rdata"}, dr, m.dr);
  endtask

  task automatic check_all();
    chk_inst("L2", m2, 2, mem_en2, mem_we2, mem_addr2, mem_wdata2, busy2, if_ack2, d_ack2,
             if_rdata2, d_rdata2);
    chk_inst("L1", m1, 1, mem_en1, mem_we1, mem_addr1, mem_wdata1, busy1, if_ack1, d_ack1,
             if_rdata1, d_rdata1);
  endtask

  task automatic tick();
    m2 = nxt(m2, 2);
    m1 = nxt(m1, 1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int na1, ne1, na2, nack;
    logic exp_fetch;
    m1 = '0;
    m2 = '0;

    // Reset state
    #1;
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Load 0x0010 returning 0xBEEF
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010; mem_rdata = 16'hBEEF;
    tick(); chk("ld_en_c1", 16'(mem_en2), 16'd1); chk("ld_addr_c1", mem_addr2, 16'h0010);
    tick(); chk("ld_en_c2", 16'(mem_en2), 16'd1);
    tick(); chk("ld_ack_c3", 16'(d_ack2), 16'd1); chk("ld_rdata_c3", d_rdata2, 16'hBEEF);
    chk("ld_en_c3", 16'(mem_en2), 16'd0);
    d_req = 1'b0;
    tick(); chk("ld_busy_c4", 16'(busy2), 16'd0);

    // Simultaneous fetch and store: data first
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick(); chk("st_we", 16'(mem_we2), 16'd1); chk("st_wdata", mem_wdata2, 16'h1234);
    chk("st_addr", mem_addr2, 16'h0020);
    tick();
    tick(); chk("st_ack", 16'(d_ack2), 16'd1);
    d_req = 1'b0; d_we = 1'b0;
    tick(); chk("st_keeps_drdata", d_rdata2, 16'hBEEF);
    tick(); chk("if_addr", mem_addr2, 16'h0004); chk("if_we", 16'(mem_we2), 16'd0);
    tick();
    tick(); chk("if_ack_after4", 16'(if_ack2), 16'd1);
    if_req = 1'b0;
    tick();

    // Flush during fetch
    if_req = 1'b1; if_addr = 16'h0008; mem_rdata = 16'h5555;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0; chk("fl_en_c2", 16'(mem_en2), 16'd1);
    tick(); chk("fl_noack", 16'(if_ack2), 16'd0); chk("fl_busy_c3", 16'(busy2), 16'd1);
    tick(); chk("fl_idle_c4", 16'(busy2), 16'd0);
    flush = 1'b1;
    tick(); chk("fl_nogrant", 16'(busy2), 16'd0);
    if_req = 1'b0; flush = 1'b0;
    tick();

    // Reset in the middle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hA5A5;
    tick(); chk("rs_we_c1", 16'(mem_we2), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    m1 = '0;
    m2 = '0;
    chk("rs_en", 16'(mem_en2), 16'd0); chk("rs_we", 16'(mem_we2), 16'd0);
    chk("rs_busy", 16'(busy2), 16'd0);
    check_all();
    d_req = 1'b0; d_we = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    d_req = 1'b1; d_addr = 16'h0030; mem_rdata = 16'h7E57;
    tick(); tick(); tick();
    chk("rs_ld_ack", 16'(d_ack2), 16'd1); chk("rs_ld_rdata", d_rdata2, 16'h7E57);
    d_req = 1'b0;
    tick();

    // Both requesters held continuously
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; if_req = 1'b1; if_addr = 16'h0200;
    nack = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (if_ack2 || d_ack2) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_fetch = (nack % 3 == 2);
`else
        exp_fetch = 1'b0;
`endif
        chk("starve_owner", 16'(if_ack2), 16'(exp_fetch));
        nack++;
      end
    end
    chk("starve_nack", 16'(nack), 16'd7);
    d_req = 1'b0; if_req = 1'b0;
    repeat (4) tick();

    // Back-to-back fetches: period lat+2
    if_req = 1'b1; if_addr = 16'h0300;
    na1 = 0; ne1 = 0; na2 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      na1 += int'(if_ack1);
      ne1 += int'(mem_en1);
      na2 += int'(if_ack2);
    end
    chk("l1_acks", 16'(na1), 16'd4);
    chk("l1_en_cycles", 16'(ne1), 16'd4);
    chk("l2_acks", 16'(na2), 16'd3);
    if_req = 1'b0;
    repeat (4) tick();

    // Random traffic with handshake-respecting requesters
    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(0, 7) == 0);
      if (!if_req || (m2.phase == 3 && !m2.owner && !m2.cancel) || flush) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = 16'($urandom);
      end
      if (!d_req || (m2.phase == 3 && m2.owner)) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      mem_rdata = 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter that shares the processor's single-ported data/instruction memory between the fetch stage and the load/store (execute) stage. It accepts one request per port through a req/ack handshake and grants one owner at a time. It holds the memory strobes for a fixed access latency and returns registered read data with a single-cycle acknowledge. A taken-branch flush cancels the delivery of an in-flight instruction fetch.

## Interface
- MEM_LAT, 2, memory access cycles per transaction (≥1)
- ADDR_W, 16, address width
- DATA_W, 16, data width

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle on loads
- d_rdata  out  DATA_W  load data
- flush  in  1  taken branch; cancels the current or pending fetch
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last access cycle
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If d_req is high, owner = DATA.
  - Otherwise, if if_req is high and flush is low, owner = FETCH.
  - When either condition holds, latch the address, data and we into mem_* and move to ACCESS with cnt = 0.
- ACCESS:
  - mem_en = 1; mem_we = owner==DATA & latched we.
  - cnt increments each cycle.
  - When cnt == MEM_LAT-1, capture mem_rdata into the owner's rdata register (loads and fetches only) and move to DONE.
- DONE:
  - Pulse the owner's ack. A FETCH ack is suppressed if the cancel flag is set.
  - Then go to IDLE, always. The port that owned the transaction is therefore never re-granted on its own ack cycle.
- Cancel flag: set when flush = 1 while owner = FETCH in ACCESS or DONE; cleared on entry to IDLE. A cancelled fetch still completes its memory cycles, so the memory never sees a truncated strobe.
- Stores leave d_rdata unchanged.
- if_rdata and d_rdata hold their values until the next capture on the same port.
- Requests that are dropped before being granted are ignored.
- Simultaneous if_req and d_req in IDLE: DATA wins (subject to the Configuration section).

## Timing
- Reset (reset = 0, asynchronous):
  - State → IDLE, cnt → 0, cancel flag and fairness counter cleared.
  - All outputs → 0 immediately, including mem_en mid-access.
  - No ack is issued for an aborted transaction.
- Request sampled in IDLE at cycle 0:
  - mem_en is high in cycles 1..MEM_LAT.
  - ack is high in cycle MEM_LAT+1.
  - State is back in IDLE at cycle MEM_LAT+2.
- Throughput: one transaction per MEM_LAT+2 cycles.
- mem_* outputs are registered and stable for the whole ACCESS period. Outside ACCESS, mem_en and mem_we are 0.
- busy is registered and high from cycle 1 through cycle MEM_LAT+1.
- A requester may present a new request in the cycle after its ack; it is sampled in the next IDLE.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 2-bit counter counts consecutive DATA grants made while if_req was high and flush was low.
  - When the counter reaches 2, the next IDLE with both requests high grants FETCH.
  - The counter clears on any FETCH grant, and whenever a DATA grant is made with if_req low.
- ARB_STARVE_GUARD_EN not defined: strict DATA priority and no counter logic.

## Structure
- Package mem_arb_pkg holds:
  - The state enum (IDLE, ACCESS, DONE).
  - The owner encoding (FETCH = 0, DATA = 1).
  - The default MEM_LAT constant.
- One sub-module, mem_arb_latcnt: the ACCESS cycle counter with a terminal-count output parameterised by MEM_LAT.
- The fairness counter lives inline under the macro.

## Test plan
- MEM_LAT=2, load d_addr=0x0010 with mem_rdata=0xBEEF in the last access cycle → mem_en high in cycles 1–2, d_ack in cycle 3 with d_rdata=0xBEEF, busy low in cycle 4.
- if_req(0x0004) and d_req store (0x0020 ← 0x1234) raised together → DATA granted first (mem_we=1, mem_wdata=0x1234, mem_addr=0x0020), then FETCH at 0x0004; if_ack follows 4 cycles after d_ack.
- Fetch at 0x0008 with flush pulsed in cycle 1 → mem_en still high for 2 cycles, no if_ack, IDLE in cycle 4; flush asserted in IDLE with if_req high → no grant that cycle.
- Assert reset in cycle 1 of a store → mem_en/mem_we/busy drop to 0 immediately with no d_ack; after release, a new load completes normally.
- ARB_STARVE_GUARD_EN defined, d_req and if_req held continuously → grant order DATA, DATA, FETCH, DATA, DATA, FETCH; without the macro → DATA only while d_req stays high.
- MEM_LAT=1 boundary → mem_en high for 1 cycle, ack in cycle 2, back-to-back fetches every 3 cycles.
